// File: rtl/contador_pkg.sv
// Shared definitions for the parametrised up/down counter family.
// Holds the mode encodings, a constant-safe clog2 and the prescaler width helper.
// Pure declarations; no logic or state lives here.
package contador_pkg;

  // Boundary behaviour encodings for the SATURATE parameter.
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Number of bits needed to encode values 0..value-1 (0 for value <= 1).
  function automatic int clog2(input longint unsigned value);
    longint unsigned v;
    int              r;
    r = 0;
    if (value > 1) begin
      v = value - 1;
      while (v > 0) begin
        r = r + 1;
        v = v >> 1;
      end
    end
    return r;
  endfunction

  // Prescaler phase register width; never narrower than one bit so the
  // register declaration stays legal even in corner configurations.
  function automatic int pre_width(input int prescale);
    int w;
    w = clog2(longint'(prescale));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/contador_prescaler.sv
// Enable prescaler: emits one tick every PRESCALE enabled cycles.
// Latency: tick is combinational from en and the registered phase.
// Phase holds while en=0; sync_clr restarts the phase from zero.
module contador_prescaler
  import contador_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  generate
    if (PRESCALE <= 1) begin : g_bypass
      // Every enabled cycle is a step; no phase register is needed.
      assign tick = en;

      // Clock, reset and clear have no function in this configuration.
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst_n, sync_clr};
    end else begin : g_count
      localparam int             PW       = pre_width(PRESCALE);
      localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] pre_q;
      logic [PW-1:0] pre_d;
      logic          at_last;

      assign at_last = (pre_q == PRE_LAST);

      // Next phase: clear wins, then advance or wrap while enabled, else hold.
      always_comb begin
        pre_d = pre_q;
        if (sync_clr) begin
          pre_d = '0;
        end else if (en) begin
          if (at_last) begin
            pre_d = '0;
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end
      end

      // Phase register; reset forgets any partially accumulated period.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pre_q <= '0;
        end else begin
          pre_q <= pre_d;
        end
      end

      // A step fires on the last enabled cycle of the period.
      assign tick = en && at_last;
    end
  endgenerate

endmodule

// File: rtl/contador_param.sv
// WIDTH-bit up/down counter, range 0..MAX, wrap or saturate, with clear/load/prescaler.
// Latency: out and tc are registered and reflect the edge that updates the count.
// No backpressure; clr > load > step priority, clr and load act regardless of en.
module contador_param
  import contador_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter int unsigned MAX       = (WIDTH >= 32) ? 32'hFFFF_FFFF
                                                   : ((32'd1 << WIDTH) - 32'd1),
  parameter int          SATURATE  = MODE_WRAP,
  parameter int          PRESCALE  = 1,
  parameter int          ZERO_IDLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);
  localparam bit               SAT_EN  = (SATURATE == MODE_SAT);
  localparam bit               IDLE_Z  = (ZERO_IDLE != 0);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic             tc_q;
  logic             tc_d;
  logic             step;
  logic             pre_clr;
  logic [WIDTH-1:0] load_clamped;
  logic             at_max;
  logic             at_zero;

  // Both clear and load restart the prescaler phase.
  assign pre_clr = clr | load;

  contador_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sync_clr (pre_clr),
    .tick     (step)
  );

  // Boundary detection is done on the current count so the step never
  // has to compute a value outside 0..MAX.
  assign at_max       = (cnt_q == MAX_V);
  assign at_zero      = (cnt_q == '0);
  assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

  // Next count and terminal-count pulse, in clr > load > step priority.
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_clamped;
    end else if (step) begin
      if (up_dn) begin
        if (at_max) begin
          tc_d  = 1'b1;
          cnt_d = SAT_EN ? MAX_V : '0;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          tc_d  = 1'b1;
          cnt_d = SAT_EN ? '0 : MAX_V;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end
  end

  // Output tracks the post-edge count; optionally blanked while idle.
  always_comb begin
    out_d = cnt_d;
    if (IDLE_Z && !en) begin
      out_d = '0;
    end
  end

  // Count, output and pulse registers; reset clears all of them at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      out_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
      tc_q  <= tc_d;
    end
  end

  assign out = out_q;
  assign tc  = tc_q;

endmodule

// File: doc/contador_param.md
# contador_param

Parametrised successor to the team's fixed 8-bit enable counter: a WIDTH-bit up/down counter with programmable terminal value, wrap or saturate mode, synchronous clear and load, an enable prescaler and a registered terminal-count pulse. It sits in the same timing and measurement paths as the 8-bit counter and replaces it in new designs. With default parameters and `up_dn=1`, `load=0` and `clr=0` held, it is cycle-equivalent to the 8-bit counter, including forcing the output to zero while idle.

## Interface
- `WIDTH`, 8: counter and output width, 2 to 32.
- `MAX`, 2**WIDTH-1: terminal value. Count range is 0..MAX; requires 1 ≤ MAX ≤ 2**WIDTH-1.
- `SATURATE`, 0: 0 = wrap at the boundary, 1 = hold at the boundary.
- `PRESCALE`, 1: number of enabled cycles per count step, 1 to 2**16.
- `ZERO_IDLE`, 1: 1 = `out` is forced to 0 while `en=0`; 0 = `out` shows the held count.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  count enable, feeds the prescaler.
- `up_dn`  in  1  direction: 1 = up, 0 = down. Sampled on step cycles only.
- `clr`  in  1  synchronous clear of the count and the prescaler.
- `load`  in  1  synchronous load of `load_val`.
- `load_val`  in  WIDTH  load value, clamped to MAX.
- `out`  out  WIDTH  registered count output.
- `tc`  out  1  registered one-cycle pulse on a boundary step.

## Operation
- Internal registers: `cnt[WIDTH]` and `pre[clog2(PRESCALE)]`. Reset value of `cnt`, `pre`, `out` and `tc` is 0.
- Priority per edge: `rst_n` > `clr` > `load` > step. `clr` and `load` act regardless of `en`, and both zero `pre`.
- Step condition: `en=1` and `pre==PRESCALE-1`. On a step, `pre` returns to 0.
- While `en=1` and no step occurs, `pre` increments. While `en=0`, `pre` holds.
- Up step:
  - `cnt<MAX`: `cnt+1`.
  - `cnt==MAX`: wrap mode goes to 0; saturate mode holds MAX. `tc=1` in both modes.
- Down step:
  - `cnt>0`: `cnt-1`.
  - `cnt==0`: wrap mode goes to MAX; saturate mode holds 0. `tc=1` in both modes.
- `tc` is 0 on every edge without a boundary step, so it never stays high for two cycles without a second boundary step. A saturated counter with `en=1` and `PRESCALE=1` keeps `tc` high every cycle. This is intended.
- Load: `cnt <= min(load_val, MAX)`. `tc=0`.
- Clear: `cnt <= 0`. `tc=0`.
- Output, registered:
  - `ZERO_IDLE=1`: `out <= en ? cnt_next : 0`.
  - `ZERO_IDLE=0`: `out <= cnt_next`.
  - `cnt_next` is the post-edge count value.
- The count never leaves the range 0..MAX. All arithmetic is WIDTH bits; there is no overflow beyond MAX because the boundary is tested before stepping.
- Reset mid-operation clears everything immediately and asynchronously, including a pending prescaler phase. The first step after reset release needs a full PRESCALE enabled cycles.

## Timing
- Latency: `out` reflects a step, load or clear on the same edge that performs it. `out` is valid one cycle after the input is sampled.
- `tc` is asserted in the cycle following the boundary edge, aligned with `out`.
- `en` falling (ZERO_IDLE=1): `out=0` from the next edge; `cnt` is preserved. `en` rising: `out` shows `cnt` or `cnt±1` from the next edge.
- `load` and `clr` together: `clr` wins.
- `load` and step together: the load wins and the step is discarded.
- No combinational input-to-output paths.

## Structure
- Package `contador_pkg`: the `clog2` function, the mode localparams `MODE_WRAP=0` and `MODE_SAT=1`, and the PRESCALE width helper.
- Sub-module `contador_prescaler` (parameter PRESCALE; ports `clk`, `rst_n`, `en`, `sync_clr`, `tick`). When PRESCALE=1 it degenerates to `tick=en` with no registers.
- Top level holds the `cnt`/`out`/`tc` registers and the boundary logic.

## Test plan
- Defaults, `en=1` for 257 cycles from reset: `out` goes 1..255, then 0. `tc` is high the cycle `out` shows 0. Dropping `en` gives `out=0` next cycle; re-enabling resumes from the held count.
- MAX=9, SATURATE=0, down from `load_val=2`: `out` goes 2, 1, 0, 9, 8. `tc` is high with the 9 only.
- MAX=9, SATURATE=1, up from 7: `out` goes 8, 9, 9, 9. `tc` is high on each edge that tries to pass 9.
- PRESCALE=4, `en=1`: `out` increments every 4th cycle. `en` low for 2 cycles mid-phase stretches that step by 2. `clr` mid-phase gives `out=0` and restarts the 4-cycle phase.
- `load_val=200` with MAX=100 gives `out=100`. `load` and `clr` together give 0. `load` and step together give the load value, no `tc`.
- `rst_n` asserted asynchronously between edges while `out=5`, `tc=1`: both are 0 immediately. After release, the first step needs a full prescale period.
